mux_ext_pipe: RTL

Parametrised, pipelined N-way select mux with load-data extension and valid/ready flow control. It generalises the fixed 4-input, 65-bit datapath select to any width and input count. It adds registered stages, backpressure, and a selectable zero/sign-extension mode for byte, half and word load results. It sits between the data-memory read port and the writeback bus, replacing the combinational load-result mux.

---
 rtl/mux_ext_pipe.sv | 115 +++++++++++
 1 files changed

// File: rtl/mux_ext_pipe.sv
// Two-stage pipelined N-way select mux with zero/sign load-data extension.
// S1 captures the selected word; S2 extends it; valid/ready on both ends.
module mux_ext_pipe #(
  parameter int WIDTH  = 65,
  parameter int INPUTS = 4,
  parameter int SELW   = $clog2(INPUTS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [INPUTS-1:0][WIDTH-1:0]   ins,
  input  logic [SELW-1:0]                select,
  input  logic [2:0]                     ext_mode,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic                           out_err
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q,  s1_data_d;
  logic [2:0]       s1_mode_q,  s1_mode_d;
  logic             s1_err_q,   s1_err_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_data_q,  s2_data_d;
  logic             s2_err_q,   s2_err_d;

  logic             in_fire;
  logic             s1_move;
  logic             out_fire;
  logic [WIDTH-1:0] sel_data;
  logic             sel_err;

  function automatic logic [WIDTH-1:0] extend(input logic [WIDTH-1:0] d,
                                              input logic [2:0]       mode);
    logic [WIDTH-1:0] r;
    r = d;
    case (mode)
      3'd1: r = {{(WIDTH-8){1'b0}},    d[7:0]};
      3'd2: r = {{(WIDTH-8){d[7]}},    d[7:0]};
      3'd3: r = {{(WIDTH-16){1'b0}},   d[15:0]};
      3'd4: r = {{(WIDTH-16){d[15]}},  d[15:0]};
      3'd5: r = {{(WIDTH-32){1'b0}},   d[31:0]};
      3'd6: r = {{(WIDTH-32){d[31]}},  d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  assign in_ready = !s1_valid_q || !s2_valid_q || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign s1_move  = s1_valid_q && (!s2_valid_q || out_ready);
  assign out_fire = s2_valid_q && out_ready;

  // An out-of-range select matches no input, so the captured word stays zero.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < INPUTS; i++) begin
      if (select == SELW'(i)) sel_data = ins[i];
    end
  end

  assign sel_err = (int'(select) >= INPUTS);

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_mode_d  = s1_mode_q;
    s1_err_d   = s1_err_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_err_d   = s2_err_q;

    if (out_fire) s2_valid_d = 1'b0;
    if (s1_move) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b1;
      s2_data_d  = extend(s1_data_q, s1_mode_q);
      s2_err_d   = s1_err_q;
    end
    // in_ready with S1 full implies S1 drains this edge, so no overwrite.
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_data_d  = sel_data;
      s1_mode_d  = ext_mode;
      s1_err_d   = sel_err;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= '0;
      s1_err_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_mode_q  <= s1_mode_d;
      s1_err_q   <= s1_err_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_err_q   <= s2_err_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_err   = s2_err_q;

endmodule
